// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 3-requester round-robin grant FSM for the shared resource.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   r[3:1]    - request vector, r[k]=1 means requester k wants the resource
//   g[3:1]    - one-hot-or-zero grant, decoded from registered state
//   gid[1:0]  - encoded grant (0 = none, 1..3 = granted requester)
//   busy      - any grant active
//   hold_cnt  - cycles the current grant has been held minus 1, 0 when idle
//
// Build option: define GRANT_TIMEOUT_EN to force a handover once a grant has
// been held MAX_HOLD cycles while another requester is waiting.
module rr_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:1]       r,
  output logic [3:1]       g,
  output logic [1:0]       gid,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

`ifdef GRANT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_SAT   = '1;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  // State code doubles as the granted requester id.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2,
    G3   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lp_q, lp_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  // One-hot decode of a requester id (0 -> no bit).
  function automatic logic [3:1] id_to_onehot(input logic [1:0] k);
    case (k)
      2'd1:    id_to_onehot = 3'b001;
      2'd2:    id_to_onehot = 3'b010;
      2'd3:    id_to_onehot = 3'b100;
      default: id_to_onehot = 3'b000;
    endcase
  endfunction

  // First requester in search order starting after lp, wrapping 3->1.
  function automatic logic [1:0] pick(input logic [3:1] req, input logic [1:0] lp);
    pick = 2'd0;
    case (lp)
      2'd1: begin
        if      (req[2]) pick = 2'd2;
        else if (req[3]) pick = 2'd3;
        else if (req[1]) pick = 2'd1;
      end
      2'd2: begin
        if      (req[3]) pick = 2'd3;
        else if (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
      end
      default: begin
        if      (req[1]) pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else if (req[3]) pick = 2'd3;
      end
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lp_q    <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  logic [1:0] cur_id;
  logic [1:0] win_id;
  logic       held;
  logic       force_rel;

  always_comb begin
    state_d   = state_q;
    lp_d      = lp_q;
    hold_d    = hold_q;
    cur_id    = 2'(state_q);
    held      = |(r & id_to_onehot(cur_id));
    win_id    = 2'd0;
    force_rel = 1'b0;

    if (state_q == IDLE) begin
      win_id = pick(r, lp_q);
      if (win_id != 2'd0) begin
        state_d = state_e'(win_id);
        lp_d    = win_id;
        hold_d  = '0;
      end
    end else begin
      // Candidates exclude the current holder, so it ranks lowest next round.
      win_id    = pick(r & ~id_to_onehot(cur_id), cur_id);
      force_rel = TIMEOUT_EN && (hold_q == HOLD_LIMIT) && (win_id != 2'd0);
      if (held && !force_rel) begin
        if (hold_q != HOLD_SAT) hold_d = hold_q + CNT_W'(1);
      end else begin
        // Direct handover, or IDLE when nobody else is waiting.
        state_d = state_e'(win_id);
        hold_d  = '0;
        if (win_id != 2'd0) lp_d = win_id;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    g        = id_to_onehot(2'(state_q));
    gid      = 2'(state_q);
    busy     = (state_q != IDLE);
    hold_cnt = hold_q;
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter with a queue-based scoreboard.
module tb_rr_grant_arbiter;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 4;

  typedef struct packed {
    logic [3:1]       g;
    logic [1:0]       gid;
    logic             busy;
    logic [CNT_W-1:0] hold;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:1]       r;
  logic [3:1]       g;
  logic [1:0]       gid;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .r        (r),
    .g        (g),
    .gid      (gid),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:1] v);
    case (v)
      3'b001:  enc = 2'd1;
      3'b010:  enc = 2'd2;
      3'b100:  enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, push the expected result, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic [3:1] rv,
                      input logic [3:1] eg, input logic [CNT_W-1:0] eh);
    exp_t e;
    reset = rst;
    r     = rv;
    e.g    = eg;
    e.gid  = enc(eg);
    e.busy = |eg;
    e.hold = eh;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".g"},    32'(g),        32'(e.g));
    check({tag, ".gid"},  32'(gid),      32'(e.gid));
    check({tag, ".busy"}, 32'(busy),     32'(e.busy));
    check({tag, ".hold"}, 32'(hold_cnt), 32'(e.hold));
  endtask

  initial begin
    logic [3:1] rot;
    reset = 1'b1;
    r     = 3'b111;

    // Reset with all requests, then first grant goes to requester 1.
    step("rst0", 1'b1, 3'b111, 3'b000, 4'd0);
    step("rst1", 1'b1, 3'b111, 3'b000, 4'd0);
    step("rel",  1'b0, 3'b111, 3'b001, 4'd0);
    step("idle", 1'b0, 3'b000, 3'b000, 4'd0);

    // Hold then direct handovers with no gap.
    step("h1a", 1'b0, 3'b001, 3'b001, 4'd0);
    step("h1b", 1'b0, 3'b001, 3'b001, 4'd1);
    step("h1c", 1'b0, 3'b001, 3'b001, 4'd2);
    step("ho2", 1'b0, 3'b110, 3'b010, 4'd0);
    step("h2",  1'b0, 3'b110, 3'b010, 4'd1);
    step("ho3", 1'b0, 3'b100, 3'b100, 4'd0);
    step("id3", 1'b0, 3'b000, 3'b000, 4'd0);

    // Fairness: establish lp=2, then all request from IDLE.
    step("lp2",  1'b0, 3'b010, 3'b010, 4'd0);
    step("id2",  1'b0, 3'b000, 3'b000, 4'd0);
    step("f3",   1'b0, 3'b111, 3'b100, 4'd0);
    step("f1",   1'b0, 3'b011, 3'b001, 4'd0);
    step("f2",   1'b0, 3'b010, 3'b010, 4'd0);
    step("f2to3", 1'b0, 3'b101, 3'b100, 4'd0);
    step("fid",  1'b0, 3'b000, 3'b000, 4'd0);

    // Continuous contention.
    for (int i = 0; i < 16; i++) begin
`ifdef GRANT_TIMEOUT_EN
      case ((i / MAX_HOLD) % 3)
        0:       rot = 3'b001;
        1:       rot = 3'b010;
        default: rot = 3'b100;
      endcase
      step("rot", 1'b0, 3'b111, rot, CNT_W'(i % MAX_HOLD));
`else
      rot = 3'b001;
      step("sat", 1'b0, 3'b111, rot, CNT_W'(i > 15 ? 15 : i));
`endif
    end
    step("cid", 1'b0, 3'b000, 3'b000, 4'd0);

    // Lone requester never forcibly released; counter saturates.
    for (int i = 0; i < 20; i++) begin
      step("lone", 1'b0, 3'b001, 3'b001, CNT_W'(i > 15 ? 15 : i));
    end

    // Reset mid-grant, lp returns to 3.
    step("g2",   1'b0, 3'b010, 3'b010, 4'd0);
    step("rmid", 1'b1, 3'b010, 3'b000, 4'd0);
    step("rpri", 1'b0, 3'b011, 3'b001, 4'd0);

    // Unknown request values, then known: grant stays one-hot-or-zero.
    reset = 1'b0;
    r     = 3'bx1x;
    @(posedge clk);
    r = 3'b000;
    @(posedge clk);
    #1;
    check("x_onehot0", 32'($onehot0(g)), 32'd1);
    @(posedge clk);
    #1;
    check("x_idle_g", 32'(g), 32'd0);
    check("x_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- 3-requester arbiter for the shared resource, with round-robin fairness.
- Replaces the fixed-priority r1>r2>r3 grant FSM with a rotating-priority FSM.
- A grant is held while its request stays high. Optionally it is forcibly released after MAX_HOLD cycles when others are waiting.
- Sits between requester blocks (r[3:1]) and the shared-resource mux (g[3:1], gid).

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles before forced handover (GRANT_TIMEOUT_EN only); legal range 2..2**CNT_W-1.
- CNT_W, 4: width of hold counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- r  input  [3:1]  request vector; r[k]=1 means requester k wants the resource.
- g  output  [3:1]  registered one-hot-or-zero grant vector.
- gid  output  [1:0]  encoded grant: 0 = none, 1..3 = granted requester.
- busy  output  1  1 when any g bit is set.
- hold_cnt  output  [CNT_W-1:0]  cycles the current grant has been held, minus 1; 0 when idle.

Behaviour:
- Reset: sampled on rising clk only. While reset=1 at an edge:
  - g=000, gid=0, busy=0, hold_cnt=0, state=IDLE.
  - last-granted pointer lp=3, so priority after reset is 1>2>3.
  - Reset mid-grant drops g on that same edge.
- States: IDLE, G1, G2, G3. Outputs are decoded from registered state, so no combinational path from r to g.
- Latency: a request sampled at edge n gives g at edge n (visible after the edge), i.e. one cycle from r rising to g rising.
- Priority search order starts at lp+1 and wraps 3->1, e.g.:
  - lp=1: order 2,3,1.
  - lp=2: order 3,1,2.
- IDLE:
  - If any r bit is set, go to Gk for the first requester in search order; set lp=k and hold_cnt=0.
  - Otherwise stay in IDLE.
- Gk, r[k]=1:
  - Stay in Gk.
  - hold_cnt increments, saturating at 2**CNT_W-1.
- Gk, r[k]=0 (release):
  - On the same edge, grant the next requester in search order (from lp=k) among the other r bits.
  - If none, go to IDLE.
  - Handover is direct: no idle cycle between grants.
- At most one g bit is ever set. g is never set for a requester whose r was 0 at the deciding edge.
- Simultaneous release by k and new requests: the new winner is chosen from the current r, excluding k.
- Requester k re-asserting immediately after release: it is eligible, but at lowest priority.
- Grant changes only on a clock edge. r changing between edges has no effect until the next edge.
- X on r: not defined behaviour. The bench checks only that g stays one-hot-or-zero after r returns to known values.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - In Gk, if hold_cnt == MAX_HOLD-1 and any other r bit is set, the grant is forcibly handed over on that edge to the next requester in search order (lp=k). This happens even though r[k]=1.
  - If no other requester is waiting, Gk holds and hold_cnt saturates.
  - Guarantees worst-case wait of 2*MAX_HOLD cycles.
- Not defined:
  - No forced release; a grant is held until r[k] drops. hold_cnt is still maintained.
  - No timeout logic is synthesised.

Test Plan:
1. Reset high 2 cycles with r=111, then release reset -> g=000 while in reset; g=001, gid=1 one cycle after release.
2. r=001 held 3 cycles, then r=110 -> g=001 for 3 cycles, then g=010 on the edge r[1] falls (no g=000 gap), then g=100 after r[2] drops.
3. Fairness: after lp=2, present r=111 from IDLE -> g=100, gid=3; release r[3] -> g=001; release r[1] -> g=010.
4. GRANT_TIMEOUT_EN, MAX_HOLD=4: r=111 continuously -> g rotates 001,010,100,001 every 4 cycles; hold_cnt runs 0..3. Without the macro: g=001 forever with hold_cnt saturating at 15.
5. GRANT_TIMEOUT_EN, r=001 alone for 20 cycles -> g stays 001, no forced release, hold_cnt=15.
6. Reset mid-grant (g=010): assert reset one cycle -> g=000 on that edge. After release with r=011 -> g=001 (lp reset to 3).
